// File: rtl/viterbi_codec.sv
// Rate-1/2, K=3 convolutional encoder (G1=7, G0=5) and hard-decision 4-state
// Viterbi decoder with register-exchange survivor memory. The encoder and
// decoder paths are independent; they share only clock and reset.
module viterbi_codec #(
  parameter int unsigned TB_DEPTH = 32,
  parameter int unsigned PM_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_enable_i,
  input  logic       enc_d_i,
  output logic       enc_valid_o,
  output logic [1:0] enc_d_o,
  input  logic       dec_enable_i,
  input  logic [1:0] dec_d_i,
  output logic       dec_d_o,
  output logic       dec_valid_o
);

  // The oldest survivor bit is only ever read as the output tap, so it is
  // taken from the predecessor's stored top bit rather than kept per state.
  localparam int unsigned SW    = TB_DEPTH - 1;
  localparam int unsigned CNT_W = $clog2(TB_DEPTH);
  localparam logic [PM_W-1:0] PM_INIT = PM_W'(16);

  // Expected symbol leaving predecessor state {a,b} on input u.
  function automatic logic [1:0] exp_sym(input logic [1:0] pred_st, input logic u);
    return {u ^ pred_st[1] ^ pred_st[0], u ^ pred_st[0]};
  endfunction

  // Hamming distance between two 2-bit symbols.
  function automatic logic [1:0] hamming2(input logic [1:0] x, input logic [1:0] y);
    logic [1:0] d;
    d = x ^ y;
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction

  // Path metric plus branch metric, clamped at all-ones instead of wrapping.
  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a, input logic [1:0] b);
    logic [PM_W:0] sum;
    sum = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
    return sum[PM_W] ? '1 : sum[PM_W-1:0];
  endfunction

  // ---------------------------------------------------------------- encoder
  logic [1:0] enc_s_q, enc_s_d;      // {s1, s0}; s1 is the most recent past bit
  logic [1:0] enc_sym_q, enc_sym_d;
  logic       enc_valid_q;

  // Encoder next state: new symbol and shifted history only when enabled.
  always_comb begin
    enc_s_d   = enc_s_q;
    enc_sym_d = enc_sym_q;
    if (enc_enable_i) begin
      enc_sym_d = {enc_d_i ^ enc_s_q[1] ^ enc_s_q[0], enc_d_i ^ enc_s_q[0]};
      enc_s_d   = {enc_d_i, enc_s_q[1]};
    end
  end

  // Encoder registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enc_s_q     <= '0;
      enc_sym_q   <= '0;
      enc_valid_q <= 1'b0;
    end else begin
      enc_s_q     <= enc_s_d;
      enc_sym_q   <= enc_sym_d;
      enc_valid_q <= enc_enable_i;
    end
  end

  assign enc_d_o     = enc_sym_q;
  assign enc_valid_o = enc_valid_q;

  // ---------------------------------------------------------------- decoder
  logic [PM_W-1:0]  pm_q   [4];
  logic [PM_W-1:0]  pm_d   [4];
  logic [SW-1:0]    surv_q [4];
  logic [SW-1:0]    surv_d [4];
  logic [PM_W-1:0]  new_pm [4];
  logic [1:0]       pred   [4];
  logic [PM_W-1:0]  pm_min;
  logic [1:0]       best;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dec_valid_q, dec_valid_d;
  logic             dec_d_q, dec_d_d;

  // Add-compare-select: next state {u,a} has predecessors {a,0} (upper) and
  // {a,1} (lower); ties go to the upper predecessor.
  always_comb begin
    logic [1:0]      ns;
    logic [PM_W-1:0] cand_up;
    logic [PM_W-1:0] cand_lo;
    logic            take_lo;
    ns      = '0;
    cand_up = '0;
    cand_lo = '0;
    take_lo = 1'b0;
    for (int unsigned s = 0; s < 4; s++) begin
      ns        = 2'(s);
      cand_up   = sat_add(pm_q[{ns[0], 1'b0}], hamming2(dec_d_i, exp_sym({ns[0], 1'b0}, ns[1])));
      cand_lo   = sat_add(pm_q[{ns[0], 1'b1}], hamming2(dec_d_i, exp_sym({ns[0], 1'b1}, ns[1])));
      take_lo   = cand_lo < cand_up;
      new_pm[s] = take_lo ? cand_lo : cand_up;
      pred[s]   = {ns[0], take_lo};
    end
  end

  // Minimum new metric and best state; lowest index wins a tie.
  always_comb begin
    pm_min = new_pm[0];
    best   = '0;
    for (int unsigned s = 1; s < 4; s++) begin
      if (new_pm[s] < pm_min) begin
        pm_min = new_pm[s];
        best   = 2'(s);
      end
    end
  end

  // Decoder next state: normalised metrics, survivor exchange, output tap and
  // valid counter; everything holds while dec_enable_i is low.
  always_comb begin
    logic [1:0] ns;
    ns          = '0;
    pm_d        = pm_q;
    surv_d      = surv_q;
    cnt_d       = cnt_q;
    dec_valid_d = dec_valid_q;
    dec_d_d     = dec_d_q;
    if (dec_enable_i) begin
      for (int unsigned s = 0; s < 4; s++) begin
        ns        = 2'(s);
        pm_d[s]   = new_pm[s] - pm_min;
        surv_d[s] = {surv_q[pred[s]][SW-2:0], ns[1]};
      end
      dec_d_d = surv_q[pred[best]][SW-1];
      if (!dec_valid_q) begin
        if (cnt_q == CNT_W'(TB_DEPTH - 1)) begin
          dec_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  // Decoder registers; reset biases decoding toward the all-zero start state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned s = 0; s < 4; s++) begin
        pm_q[s]   <= (s == 0) ? '0 : PM_INIT;
        surv_q[s] <= '0;
      end
      cnt_q       <= '0;
      dec_valid_q <= 1'b0;
      dec_d_q     <= 1'b0;
    end else begin
      pm_q        <= pm_d;
      surv_q      <= surv_d;
      cnt_q       <= cnt_d;
      dec_valid_q <= dec_valid_d;
      dec_d_q     <= dec_d_d;
    end
  end

  assign dec_d_o     = dec_d_q;
  assign dec_valid_o = dec_valid_q;

endmodule

// File: tb/tb_viterbi_codec.sv
// Bench for viterbi_codec: encoder checked against a convolution of the input
// history, decoder checked in loopback against the original bit stream.
module tb_viterbi_codec;

  localparam int TB_DEPTH = 32;
  localparam int PM_W     = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enc_enable_i = 1'b0;
  logic       enc_d_i = 1'b0;
  logic       enc_valid_o;
  logic [1:0] enc_d_o;
  logic       dec_enable_i = 1'b0;
  logic [1:0] dec_d_i = 2'b00;
  logic       dec_d_o;
  logic       dec_valid_o;

  viterbi_codec #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .enc_enable_i (enc_enable_i),
    .enc_d_i      (enc_d_i),
    .enc_valid_o  (enc_valid_o),
    .enc_d_o      (enc_d_o),
    .dec_enable_i (dec_enable_i),
    .dec_d_i      (dec_d_i),
    .dec_d_o      (dec_d_o),
    .dec_valid_o  (dec_valid_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Bench state: source bits, channel error table, expected outputs.
  logic       bits     [0:1023];
  logic [1:0] flip_tab [0:1023];
  int         eidx, ch_idx, dcnt, cyc;
  int         first_sym_cyc, valid_cyc;
  logic [1:0] exp_enc;
  logic       exp_enc_vld;
  logic       exp_dec;
  logic [1:0] cap_sym;
  logic       cap_vld;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Encoder reference: symbol i is the convolution of bits i, i-1, i-2 with 7 and 5.
  function automatic logic [1:0] conv(input int i);
    logic b0, b1, b2;
    b0 = bits[i];
    b1 = (i >= 1) ? bits[i-1] : 1'b0;
    b2 = (i >= 2) ? bits[i-2] : 1'b0;
    return {b0 ^ b1 ^ b2, b0 ^ b2};
  endfunction

  // One clock: drive encoder, model a one-register channel, check all outputs.
  task automatic tick(input logic en, input logic u);
    logic consumed;
    enc_enable_i = en;
    enc_d_i      = u;
    exp_enc_vld  = en;
    if (en) begin
      bits[eidx] = u;
      exp_enc    = conv(eidx);
      if (eidx == 0) first_sym_cyc = cyc + 1;
      eidx++;
    end
    cap_vld = enc_valid_o;
    cap_sym = enc_d_o ^ (enc_valid_o ? flip_tab[ch_idx] : 2'b00);
    if (enc_valid_o) ch_idx++;
    consumed = dec_enable_i;
    @(posedge clk);
    #1;
    cyc++;
    dec_d_i      = cap_sym;
    dec_enable_i = cap_vld;
    check_eq("enc_valid", 32'(enc_valid_o), 32'(exp_enc_vld));
    check_eq("enc_d", 32'(enc_d_o), 32'(exp_enc));
    if (consumed) begin
      dcnt++;
      if (dcnt >= TB_DEPTH) exp_dec = bits[dcnt - TB_DEPTH];
    end
    if (valid_cyc < 0 && dec_valid_o === 1'b1) valid_cyc = cyc;
    check_eq("dec_valid", 32'(dec_valid_o), 32'(dcnt >= TB_DEPTH));
    check_eq("dec_d", 32'(dec_d_o), 32'(exp_dec));
  endtask

  task automatic do_reset(input int cycles);
    rst          = 1'b0;
    enc_enable_i = 1'b0;
    enc_d_i      = 1'b0;
    dec_enable_i = 1'b0;
    dec_d_i      = 2'b00;
    eidx = 0; ch_idx = 0; dcnt = 0;
    first_sym_cyc = -1; valid_cyc = -1;
    exp_enc = 2'b00; exp_enc_vld = 1'b0; exp_dec = 1'b0;
    #1;
    check_eq("rst_async_enc_d", 32'(enc_d_o), 32'd0);
    check_eq("rst_async_dec_valid", 32'(dec_valid_o), 32'd0);
    repeat (cycles) @(posedge clk);
    #1;
    check_eq("rst_enc_d", 32'(enc_d_o), 32'd0);
    check_eq("rst_enc_valid", 32'(enc_valid_o), 32'd0);
    check_eq("rst_dec_d", 32'(dec_d_o), 32'd0);
    check_eq("rst_dec_valid", 32'(dec_valid_o), 32'd0);
    rst = 1'b1;
  endtask

  task automatic clear_flips();
    for (int i = 0; i < 1024; i++) flip_tab[i] = 2'b00;
  endtask

  // n random bits, optionally with 1-4 idle cycles inserted, then a short drain.
  task automatic run_stream(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) tick(1'b0, 1'b0);
      end
      tick(1'b1, 1'($urandom_range(0, 1)));
    end
    repeat (4) tick(1'b0, 1'b0);
  endtask

  initial begin
    logic [1:0] imp_tab  [4];
    logic [1:0] hold_tab [8];
    int k;
    imp_tab  = '{2'b11, 2'b10, 2'b11, 2'b00};
    hold_tab = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    cyc = 0;
    clear_flips();
    #2;
    do_reset(3);

    // Encoder impulse response.
    tick(1'b1, 1'b1); check_eq("imp0", 32'(enc_d_o), 32'(imp_tab[0]));
    tick(1'b1, 1'b0); check_eq("imp1", 32'(enc_d_o), 32'(imp_tab[1]));
    tick(1'b1, 1'b0); check_eq("imp2", 32'(enc_d_o), 32'(imp_tab[2]));
    tick(1'b1, 1'b0); check_eq("imp3", 32'(enc_d_o), 32'(imp_tab[3]));

    // Encoder hold across a 5-cycle enable gap.
    tick(1'b1, 1'b1); check_eq("hold0", 32'(enc_d_o), 32'(hold_tab[0]));
    tick(1'b1, 1'b1); check_eq("hold1", 32'(enc_d_o), 32'(hold_tab[1]));
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'($urandom_range(0, 1)));
      check_eq("hold_gap", 32'(enc_d_o), 32'(hold_tab[2 + i]));
    end
    tick(1'b1, 1'b0); check_eq("hold7", 32'(enc_d_o), 32'(hold_tab[7]));

    // Clean loopback with continuous enables, plus end-to-end latency.
    do_reset(3);
    run_stream(256 + TB_DEPTH + 2, 1'b0);
    check_eq("latency", 32'(valid_cyc - first_sym_cyc), 32'(TB_DEPTH + 1));

    // Single-bit errors every 8 symbols.
    clear_flips();
    for (int i = 4; i < 256; i += 8) flip_tab[i] = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
    do_reset(3);
    run_stream(256 + TB_DEPTH + 2, 1'b0);

    // Both bits of one symbol flipped, errors 16..24 symbols apart.
    clear_flips();
    k = 10;
    while (k < 256) begin
      flip_tab[k] = 2'b11;
      k += int'($urandom_range(16, 24));
    end
    do_reset(3);
    run_stream(256 + TB_DEPTH + 2, 1'b0);

    // Random enable gaps.
    clear_flips();
    do_reset(3);
    run_stream(256 + TB_DEPTH + 2, 1'b1);

    // Reset mid-stream at bit 100, then a fresh stream.
    do_reset(3);
    for (int i = 0; i < 100; i++) tick(1'b1, 1'($urandom_range(0, 1)));
    do_reset(2);
    run_stream(150 + TB_DEPTH, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
